// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the reaction timer display.
// Scans one digit per REFRESH_DIV clocks and blinks the "FAIL" text in fail mode.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 2,
    parameter int BLINK_DIV   = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] fstate,
    input  logic [4:0] cur0,
    input  logic [4:0] cur1,
    input  logic [4:0] cur2,
    input  logic [4:0] cur3,
    input  logic [4:0] bst0,
    input  logic [4:0] bst1,
    input  logic [4:0] bst2,
    input  logic [4:0] bst3,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_PREP   = 3'b001,
        ST_RESULT = 3'b010,
        ST_TEST   = 3'b011,
        ST_FAIL   = 3'b100,
        ST_BEST   = 3'b101,
        ST_NULL   = 3'b110,
        ST_UNUSED = 3'b111
    } fstate_t;

    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLINK_LAST   = 16'(BLINK_DIV - 1);
    localparam logic [4:0]  CODE_BLANK   = 5'd31;

    logic [15:0] refresh_cnt, refresh_nxt;
    logic [15:0] blink_cnt, blink_nxt;
    logic [1:0]  index, index_nxt;
    logic        blink_on, blink_on_nxt;
    logic [2:0]  fstate_q;
    logic [4:0]  cur_sel, bst_sel, fail_sel, code;
    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    function automatic logic [6:0] decode(input logic [4:0] c);
        case (c)
            5'd0:    decode = 7'b1000000;
            5'd1:    decode = 7'b1111001;
            5'd2:    decode = 7'b0100100;
            5'd3:    decode = 7'b0110000;
            5'd4:    decode = 7'b0011001;
            5'd5:    decode = 7'b0010010;
            5'd6:    decode = 7'b0000010;
            5'd7:    decode = 7'b1111000;
            5'd8:    decode = 7'b0000000;
            5'd9:    decode = 7'b0010000;
            5'd20:   decode = 7'b0001110;
            5'd21:   decode = 7'b0001000;
            5'd22:   decode = 7'b1111001;
            5'd23:   decode = 7'b0111111;
            5'd24:   decode = 7'b1000111;
            5'd25:   decode = 7'b0101011;
            5'd26:   decode = 7'b1100011;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        refresh_nxt  = refresh_cnt + 16'd1;
        index_nxt    = index;
        blink_nxt    = '0;
        blink_on_nxt = 1'b1;
        if (refresh_cnt == REFRESH_LAST) begin
            refresh_nxt = '0;
            index_nxt   = index + 2'd1;
        end

        // Entering fail mode (or any state change) restarts blinking in the on phase.
        if (fstate == ST_FAIL && fstate == fstate_q) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_nxt    = '0;
                blink_on_nxt = ~blink_on;
            end else begin
                blink_nxt    = blink_cnt + 16'd1;
                blink_on_nxt = blink_on;
            end
        end

        case (index)
            2'd0:    begin cur_sel = cur0; bst_sel = bst0; fail_sel = 5'd24; end
            2'd1:    begin cur_sel = cur1; bst_sel = bst1; fail_sel = 5'd22; end
            2'd2:    begin cur_sel = cur2; bst_sel = bst2; fail_sel = 5'd21; end
            default: begin cur_sel = cur3; bst_sel = bst3; fail_sel = 5'd20; end
        endcase

        case (fstate)
            ST_TEST, ST_RESULT: code = cur_sel;
            ST_BEST, ST_NULL:   code = bst_sel;
            ST_IDLE:            code = 5'd23;
            ST_FAIL:            code = fail_sel;
            default:            code = CODE_BLANK;
        endcase

        an_nxt  = ~(4'b0001 << index);
        seg_nxt = decode(code);
        dp_nxt  = ~(index == 2'd3 &&
                    (fstate == ST_TEST || fstate == ST_RESULT || fstate == ST_BEST));
        // Blanking uses the upcoming phase so the off phase starts on the toggle edge.
        if (!blink_on_nxt) begin
            seg_nxt = 7'b1111111;
            dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            index       <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            fstate_q    <= ST_IDLE;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
        end else begin
            refresh_cnt <= refresh_nxt;
            index       <= index_nxt;
            blink_cnt   <= blink_nxt;
            blink_on    <= blink_on_nxt;
            fstate_q    <= fstate;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: expectations are queued when a step is
// driven and compared one edge later against the registered outputs.
module tb_seg_scan_driver;

    localparam int REF   = 2;
    localparam int BLINK = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] fs = 3'b000;
    logic [4:0] cur [4];
    logic [4:0] bst [4];
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   k = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(REF), .BLINK_DIV(BLINK)) dut (
        .clk(clk), .reset(reset), .fstate(fs),
        .cur0(cur[0]), .cur1(cur[1]), .cur2(cur[2]), .cur3(cur[3]),
        .bst0(bst[0]), .bst1(bst[1]), .bst2(bst[2]), .bst3(bst[3]),
        .an(an), .seg(seg), .dp(dp)
    );

    function automatic logic [6:0] dec(input logic [4:0] c);
        case (c)
            5'd0:  return 7'b1000000;
            5'd1:  return 7'b1111001;
            5'd2:  return 7'b0100100;
            5'd3:  return 7'b0110000;
            5'd4:  return 7'b0011001;
            5'd5:  return 7'b0010010;
            5'd6:  return 7'b0000010;
            5'd7:  return 7'b1111000;
            5'd8:  return 7'b0000000;
            5'd9:  return 7'b0010000;
            5'd20: return 7'b0001110;
            5'd21: return 7'b0001000;
            5'd22: return 7'b1111001;
            5'd23: return 7'b0111111;
            5'd24: return 7'b1000111;
            5'd25: return 7'b0101011;
            5'd26: return 7'b1100011;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] src_seg(input int d);
        case (fs)
            3'b011, 3'b010: return dec(cur[d]);
            3'b101, 3'b110: return dec(bst[d]);
            3'b000:         return dec(5'd23);
            3'b100:         return (d == 0) ? dec(5'd24) : (d == 1) ? dec(5'd22) :
                                   (d == 2) ? dec(5'd21) : dec(5'd20);
            default:        return 7'b1111111;
        endcase
    endfunction

    task automatic step(input exp_t e, input string tag);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        assert (an === got.an && seg === got.seg && dp === got.dp)
        else begin
            bad++;
            $error("FAIL %s k=%0d: observed an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   tag, k, an, seg, dp, got.an, got.seg, got.dp);
        end
    endtask

    // Expected output for scan position k since reset release, from the current inputs.
    task automatic scan_step(input logic blank, input string tag);
        exp_t e;
        int d;
        logic [3:0] one;
        one = 4'b0001;
        d = (k / REF) % 4;
        e.an  = ~(one << d);
        e.seg = blank ? 7'b1111111 : src_seg(d);
        e.dp  = (!blank && d == 3 && (fs == 3'b011 || fs == 3'b010 || fs == 3'b101)) ? 1'b0 : 1'b1;
        step(e, tag);
        k++;
    endtask

    task automatic do_reset();
        exp_t e;
        e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
        reset = 1'b1;
        step(e, "reset");
        step(e, "reset_hold");
        reset = 1'b0;
        k = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            cur[i] = 5'd0;
            bst[i] = 5'd0;
        end

        // Plain scan of current time 1234 in test mode.
        fs = 3'b011;
        cur[3] = 5'd1; cur[2] = 5'd2; cur[1] = 5'd3; cur[0] = 5'd4;
        do_reset();
        for (int i = 0; i < 16; i++) scan_step(1'b0, "scan_test");

        // Best time with a blank leading digit, then "nuLL" without rescanning.
        fs = 3'b101;
        bst[3] = 5'd19; bst[2] = 5'd9; bst[1] = 5'd9; bst[0] = 5'd9;
        do_reset();
        for (int i = 0; i < 8; i++) scan_step(1'b0, "best");
        fs = 3'b110;
        bst[3] = 5'd25; bst[2] = 5'd26; bst[1] = 5'd24; bst[0] = 5'd24;
        for (int i = 0; i < 8; i++) scan_step(1'b0, "null");

        // Fail text blinks 4 on / 4 off while scanning continues; idle cancels blink.
        fs = 3'b100;
        do_reset();
        for (int i = 0; i < 18; i++) scan_step(((k / BLINK) % 2) == 1, "fail_blink");
        fs = 3'b000;
        for (int i = 0; i < 6; i++) scan_step(1'b0, "idle_after_fail");

        // Preparation and unused codes blank every digit.
        fs = 3'b001;
        for (int i = 0; i < 4; i++) scan_step(1'b0, "prep_blank");
        fs = 3'b111;
        for (int i = 0; i < 2; i++) scan_step(1'b0, "unused_blank");

        // Reset while digit index 2 is active.
        fs = 3'b011;
        do_reset();
        for (int i = 0; i < 5; i++) scan_step(1'b0, "pre_midreset");
        do_reset();
        scan_step(1'b0, "first_after_reset");

        // Decode sweep in result mode, one code per edge.
        fs = 3'b010;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            for (int i = 0; i < 4; i++) cur[i] = 5'(c);
            scan_step(1'b0, $sformatf("sweep_code%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 2: clk cycles each digit stays enabled; legal range 1..65535.
REQ-002 Parameter BLINK_DIV, default 500: clk cycles per blink half-period in fail mode; legal range 1..65535.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fstate  input  3  timer state code: 000 idle, 001 preparation, 011 test, 010 result, 100 fail, 101 best, 110 null, 111 unused.
REQ-006 cur0..cur3  input  5 each  current-time display codes; cur0 is the least significant (rightmost) digit.
REQ-007 bst0..bst3  input  5 each  best-time display codes; bst0 is the rightmost digit.
REQ-008 an  output  4  digit enables, active-low, one-hot; an[0] is the rightmost digit.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low.

Function
REQ-011 Scan: a refresh counter counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-012 an, seg and dp are registered; each clock they reflect the index, fstate and codes sampled on the previous edge (1-cycle latency), so an and seg are never misaligned.
REQ-013 Source per fstate: 011/010 -> cur[index]; 101/110 -> bst[index]; 000 -> code 23 on all digits; 001 and 111 -> blank on all digits; 100 -> fixed text, digit 3..0 = codes 20,21,22,24 ("FAIL").
REQ-014 Code decode (seg value): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 20 'F'=0001110, 21 'A'=0001000, 22 'I'=1111001, 23 '-'=0111111, 24 'L'=1000111, 25 'n'=0101011, 26 'u'=1100011.
REQ-015 Every other code (10..19, 27..31, including the 19 "no best" sentinel) decodes to blank (1111111).
REQ-016 dp is 0 only when index==3 and fstate is 011, 010 or 101; otherwise dp is 1.
REQ-017 Blink: in fail mode a blink counter counts 0..BLINK_DIV-1 and toggles a phase bit at terminal count; while the phase is off, seg=1111111 and dp=1, but an continues to scan.
REQ-018 On any fstate change, the blink counter is cleared and the phase set to on in the same edge; outside fail mode both stay cleared/on.
REQ-019 fstate or code changes mid-digit take effect on the next edge without restarting the scan.

Reset
REQ-020 While reset is high: refresh counter=0, index=0, blink counter=0, blink phase=on, an=1111, seg=1111111, dp=1.
REQ-021 On the first edge after reset is released, an=1110 and seg shows digit 0 of the selected source.
REQ-022 Reset asserted mid-scan or mid-blink takes effect on the next edge, with no partial-digit output.

Verification
REQ-023 REFRESH_DIV=2, fstate=011, cur3..0=1,2,3,4 -> an sequence 1110,1110,1101,1101,1011,1011,0111,0111 repeating; seg 0011001,0110000,0100100,1111001 follows the digits; dp=0 only with an=0111.
REQ-024 fstate=101, bst3..0=19,9,9,9 -> digit 3 blank (1111111), digits 2..0 show 0010000, dp=0 on digit 3; then fstate=110, bst3..0=25,26,24,24 -> "nuLL" patterns, dp=1.
REQ-025 BLINK_DIV=4, fstate=100 -> "FAIL" shown for 4 cycles, then seg=1111111 for 4 cycles while an keeps scanning; switching fstate to 000 -> the next edge shows 0111111 on all digits, with no blanked phase.
REQ-026 Reset pulsed while index=2 -> an=1111 and seg=1111111 during reset; the first edge after release gives an=1110.
REQ-027 Sweep codes 0..31 on cur0 with fstate=010 -> each seg value matches REQ-014/REQ-015 one cycle after the change.
